// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// The optional idle auto-flush is enabled by FIFO_RD_PACKER_TIMEOUT_EN.
package fifo_rd_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs PACK of them into one valid/ready output beat.
// Define FIFO_RD_PACKER_TIMEOUT_EN to auto-flush a partial word after TIMEOUT idle cycles.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4,
  parameter int TIMEOUT  = 16,
  localparam int OUT_W   = DATASIZE * PACK
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  input  logic                flush,
  output logic [OUT_W-1:0]    out_data,
  output logic [PACK-1:0]     out_keep,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int CW = clog2(PACK + 1);

  if (PACK < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_rd_packer: PACK must be >= 2 and TIMEOUT >= 1");
  end

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fp_q, fp_d;
  logic [OUT_W-1:0] od_q;
  logic [PACK-1:0]  ok_q, keep_acc;
  logic             ov_q;

  state_t state;
  logic   fpe;
  logic   xfer;
  logic   to_hit;

  always_comb begin
    state = FILL;
    if (cnt_q == '0)               state = IDLE;
    else if (cnt_q == CW'(PACK))   state = FULL;
  end

  // Pop, transfer and accumulator next-state in one place.
  always_comb begin
    fpe   = fp_q || flush || to_hit;
    xfer  = (state == FULL || (fpe && state != IDLE))
            && (!ov_q || out_ready);
    rinc  = !rempty && (state != FULL || xfer);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (xfer) begin
      acc_d = '0;
      cnt_d = '0;
      if (rinc) begin
        acc_d[DATASIZE-1:0] = rdata;
        cnt_d               = CW'(1);
      end
    end else if (rinc) begin
      for (int k = 0; k < PACK; k++)
        if (cnt_q == CW'(k))
          acc_d[k*DATASIZE +: DATASIZE] = rdata;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    fp_d = fp_q;
    if (xfer)
      fp_d = 1'b0;
    else if (fpe)
      fp_d = !(state == IDLE && !rinc);
  end

  always_comb begin
    keep_acc = '0;
    for (int k = 0; k < PACK; k++)
      keep_acc[k] = (CW'(k) < cnt_q);
  end

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;

  assign to_hit = (idle_q == TW'(TIMEOUT));

  always_comb begin
    idle_d = idle_q;
    if (rinc || xfer || state != FILL)
      idle_d = '0;
    else if (!to_hit)
      idle_d = idle_q + TW'(1);
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      acc_q <= '0;
      cnt_q <= '0;
      fp_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      fp_q  <= fp_d;
    end
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      od_q <= '0;
      ok_q <= '0;
      ov_q <= 1'b0;
    end else if (xfer) begin
      od_q <= acc_q;
      ok_q <= keep_acc;
      ov_q <= 1'b1;
    end else if (out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign out_data  = od_q;
  assign out_keep  = ok_q;
  assign out_valid = ov_q;
  assign busy      = (cnt_q != '0) || ov_q || fp_q;

  a_cnt_range: assert property (
    @(posedge rclk) disable iff (!rrst) cnt_q <= CW'(PACK)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FIFO model.
// Checks packing, stalls, flush, reset and the optional idle timeout.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  fifo_rd_packer #(.DATASIZE(8), .PACK(4), .TIMEOUT(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  logic [7:0]  fq[$];
  logic [31:0] bd[$];
  logic [3:0]  bk[$];
  int          bc[$];
  int          cyc = 0;
  int          pops = 0;
  int          viol = 0;
  int          last_pop = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic refresh();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // FIFO model and beat monitor.
  always @(posedge rclk) begin
    cyc++;
    if (rinc) begin
      if (fq.size() == 0) viol++;
      else begin
        void'(fq.pop_front());
        pops++;
        last_pop = cyc;
      end
    end
    if (out_valid && out_ready) begin
      bd.push_back(out_data);
      bk.push_back(out_keep);
      bc.push_back(cyc);
    end
    #1 refresh();
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic clear_beats();
    bd.delete();
    bk.delete();
    bc.delete();
  endtask

  logic [31:0] held;

  initial begin
    rrst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    refresh();
    cycles(2);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_keep", out_keep, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rinc", rinc, 1'b0);
    rrst = 1'b1;
    cycles(1);

    // 1: single full beat
    out_ready = 1'b1;
    pops = 0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    cycles(10);
    chk("t1_beats", bd.size(), 1);
    if (bd.size() >= 1) begin
      chk("t1_data", bd[0], 32'h04030201);
      chk("t1_keep", bk[0], 4'hF);
    end
    chk("t1_pops", pops, 4);

    // 2: back-to-back stream
    clear_beats();
    for (int i = 1; i <= 8; i++) push(8'(i));
    cycles(16);
    chk("t2_beats", bd.size(), 2);
    if (bd.size() >= 2) begin
      chk("t2_data0", bd[0], 32'h04030201);
      chk("t2_data1", bd[1], 32'h08070605);
      chk("t2_gap", bc[1] - bc[0], 4);
    end
    chk("t2_empty_pop", viol, 0);

    // 3: partial flush, then flush with nothing buffered
    clear_beats();
    push(8'hAA); push(8'hBB); push(8'hCC);
    cycles(6);
    chk("t3_hold_valid", out_valid, 1'b0);
    chk("t3_busy_partial", busy, 1'b1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(4);
    chk("t3_beats", bd.size(), 1);
    if (bd.size() >= 1) begin
      chk("t3_data", bd[0], 32'h00CCBBAA);
      chk("t3_keep", bk[0], 4'h7);
    end
    chk("t3_busy_after", busy, 1'b0);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("t3_idle_flush_busy", busy, 1'b0);
    cycles(4);
    chk("t3_idle_flush_beats", bd.size(), 1);

    // 4: back-pressure
    clear_beats();
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    cycles(20);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data", out_data, 32'h13121110);
    chk("t4_pops", pops, 8);
    chk("t4_rinc", rinc, 1'b0);
    held = out_data;
    cycles(5);
    chk("t4_stable", out_data, held);
    out_ready = 1'b1;
    cycles(20);
    chk("t4_beats", bd.size(), 3);
    if (bd.size() >= 3) begin
      chk("t4_b0", bd[0], 32'h13121110);
      chk("t4_b1", bd[1], 32'h17161514);
      chk("t4_b2", bd[2], 32'h1B1A1918);
    end
    chk("t4_empty_pop", viol, 0);

    // 5: asynchronous reset mid-packet
    clear_beats();
    push(8'h55); push(8'h66);
    cycles(4);
    chk("t5_busy_pre", busy, 1'b1);
    #2 rrst = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 32'h0);
    chk("t5_rst_keep", out_keep, 4'h0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_rinc", rinc, 1'b0);
    cycles(2);
    rrst = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(8'h20 + i));
    cycles(10);
    chk("t5_beats", bd.size(), 1);
    if (bd.size() >= 1) begin
      chk("t5_data", bd[0], 32'h24232221);
      chk("t5_keep", bk[0], 4'hF);
    end

    // 6: idle timeout
    clear_beats();
    push(8'h5A);
    cycles(30);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    chk("t6_beats", bd.size(), 1);
    if (bd.size() >= 1) begin
      chk("t6_data", bd[0], 32'h0000005A);
      chk("t6_keep", bk[0], 4'h1);
      chk("t6_delay", bc[0] - last_pop, 18);
    end
`else
    chk("t6_no_beat", bd.size(), 0);
    chk("t6_busy", busy, 1'b1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(4);
    chk("t6_flushed", bd.size(), 1);
`endif
    chk("final_empty_pop", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
